// File: rtl/conv_row_loader_pkg.sv
// rtl/conv_row_loader_pkg.sv - shared sizes and state encoding for the convolution row loader
// Contents: default RF geometry and pixel width, frame height, loader state enum,
//           and a counter-width helper that never returns zero.
package conv_row_loader_pkg;

  localparam int SHIFT_RF_2D_COL      = 8;
  localparam int SHIFT_RF_2D_ROW      = 8;
  localparam int DATA_WIDTH           = 16;
  localparam int SHIFT_RF_2D_ROW_WORD = SHIFT_RF_2D_COL * DATA_WIDTH;
  localparam int CONV_FRAME_ROWS      = 16;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_FILL  = 3'd1,
    LDR_ROW   = 3'd2,
    LDR_SLIDE = 3'd3,
    LDR_DONE  = 3'd4
  } ldr_state_t;

  // Index width for a counter covering 0..n-1; a single-entry counter still gets one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_row_loader_packer.sv
// rtl/conv_row_loader_packer.sv - packs accepted pixels into one RF row word
// Ports: clk, reset (async active-low), clear (drop partial row),
//        accept (pixel handshake fired), pix_in (pixel),
//        data (packed row word, slot k at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]),
//        row_full (combinational, high on the accept that fills the last slot).
module row_packer #(
  parameter int NUM_COL    = conv_row_loader_pkg::SHIFT_RF_2D_COL,
  parameter int DATA_WIDTH = conv_row_loader_pkg::DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          accept,
  input  logic [DATA_WIDTH-1:0]         pix_in,
  output logic [NUM_COL*DATA_WIDTH-1:0] data,
  output logic                          row_full
);
  import conv_row_loader_pkg::*;

  localparam int SW = cnt_width(NUM_COL);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_COL - 1);

  logic [SW-1:0] slot;

  assign row_full = accept && (slot == LAST_SLOT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot <= '0;
    end else if (clear) begin
      slot <= '0;
    end else if (accept) begin
      slot <= row_full ? '0 : slot + SW'(1);
    end
  end

  // Only the addressed slot is written; the rest of the word keeps its old pixels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
    end else if (accept && !clear) begin
      for (int k = 0; k < NUM_COL; k++) begin
        if (slot == SW'(k)) begin
          data[k*DATA_WIDTH +: DATA_WIDTH] <= pix_in;
        end
      end
    end
  end

endmodule

// File: rtl/conv_row_loader.sv
// rtl/conv_row_loader.sv - feeds pixel rows into the 2D shift RF and sweeps column alignments
// Ports: clk, reset (async active-low), flush (restart frame),
//        pix_in/pix_valid/pix_ready (pixel stream handshake),
//        data (row word to RF), rowShift (push row), colShift (rotate columns),
//        win_valid (RF holds a valid window), col_idx (window alignment),
//        row_idx (frame index of last pushed row), frame_done (end-of-frame pulse).
module conv_row_loader #(
  parameter int NUM_COL    = conv_row_loader_pkg::SHIFT_RF_2D_COL,
  parameter int NUM_ROW    = conv_row_loader_pkg::SHIFT_RF_2D_ROW,
  parameter int DATA_WIDTH = conv_row_loader_pkg::DATA_WIDTH,
  parameter int FRAME_ROWS = conv_row_loader_pkg::CONV_FRAME_ROWS
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  flush,
  input  logic [DATA_WIDTH-1:0]                                 pix_in,
  input  logic                                                  pix_valid,
  output logic                                                  pix_ready,
  output logic [NUM_COL*DATA_WIDTH-1:0]                         data,
  output logic                                                  rowShift,
  output logic                                                  colShift,
  output logic                                                  win_valid,
  output logic [conv_row_loader_pkg::cnt_width(NUM_COL)-1:0]    col_idx,
  output logic [conv_row_loader_pkg::cnt_width(FRAME_ROWS)-1:0] row_idx,
  output logic                                                  frame_done
);
  import conv_row_loader_pkg::*;

  localparam int CW = cnt_width(NUM_COL);
  localparam int RW = cnt_width(FRAME_ROWS);
  localparam int LW = $clog2(NUM_ROW + 1);

  ldr_state_t    state;
  ldr_state_t    state_next;
  logic [RW-1:0] row_cnt;          // frame index the next pushed row will get
  logic [LW-1:0] rows_loaded;
  logic [LW-1:0] rows_loaded_inc;
  logic [CW-1:0] col_cnt;
  logic          accept;
  logic          row_full;
  logic          clear;
  logic          primed;
  logic          last_row;
  logic          last_col;
  logic          aborting;

  assign aborting        = flush && (state != LDR_IDLE);
  // Flush beats a same-cycle pixel: the handshake is suppressed so the pixel is dropped.
  assign accept          = pix_valid && pix_ready && !flush;
  assign clear           = aborting || (state == LDR_DONE);
  assign rows_loaded_inc = (rows_loaded == LW'(NUM_ROW)) ? rows_loaded : rows_loaded + LW'(1);
  assign primed          = (rows_loaded_inc == LW'(NUM_ROW));
  assign last_row        = (row_idx == RW'(FRAME_ROWS - 1));
  assign last_col        = (col_cnt == CW'(NUM_COL - 1));

  row_packer #(
    .NUM_COL    (NUM_COL),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .accept   (accept),
    .pix_in   (pix_in),
    .data     (data),
    .row_full (row_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LDR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LDR_IDLE:  state_next = LDR_FILL;
      LDR_FILL:  if (row_full) state_next = LDR_ROW;
      LDR_ROW: begin
        if (primed)        state_next = LDR_SLIDE;
        else if (last_row) state_next = LDR_DONE;
        else               state_next = LDR_FILL;
      end
      LDR_SLIDE: if (last_col) state_next = last_row ? LDR_DONE : LDR_FILL;
      LDR_DONE:  state_next = LDR_FILL;
      default:   state_next = LDR_IDLE;
    endcase
    if (aborting) begin
      state_next = LDR_FILL;
    end
  end

  always_comb begin
    pix_ready  = 1'b0;
    rowShift   = 1'b0;
    colShift   = 1'b0;
    win_valid  = 1'b0;
    frame_done = 1'b0;
    case (state)
      LDR_FILL:  pix_ready  = 1'b1;
      LDR_ROW:   rowShift   = 1'b1;
      LDR_SLIDE: begin
        colShift  = 1'b1;
        win_valid = 1'b1;
      end
      LDR_DONE:  frame_done = 1'b1;
      default:   ;
    endcase
  end

  // row_idx is loaded as the row completes so it is already valid during the rowShift cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_idx <= '0;
    end else if ((state == LDR_FILL) && row_full) begin
      row_idx <= row_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cnt     <= '0;
      rows_loaded <= '0;
    end else if (clear) begin
      row_cnt     <= '0;
      rows_loaded <= '0;
    end else if (state == LDR_ROW) begin
      rows_loaded <= rows_loaded_inc;
      if (row_cnt != RW'(FRAME_ROWS - 1)) begin
        row_cnt <= row_cnt + RW'(1);
      end
    end
  end

  // NUM_COL shifts bring the RF back to its original alignment, so the counter simply
  // restarts at 0 whenever the sweep is left (normally or by flush).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_cnt <= '0;
    end else if ((state == LDR_SLIDE) && (state_next == LDR_SLIDE)) begin
      col_cnt <= col_cnt + CW'(1);
    end else begin
      col_cnt <= '0;
    end
  end

  assign col_idx = col_cnt;

endmodule

// File: tb/tb_conv_row_loader.sv
// tb/tb_conv_row_loader.sv - scoreboard bench for conv_row_loader (4 cols, 3 rows, 5-row frames, 8-bit pixels)
module tb_conv_row_loader;

  localparam int K_NONE = 0;
  localparam int K_ROW  = 1;
  localparam int K_COL  = 2;
  localparam int K_DONE = 3;

  typedef struct packed {
    logic [1:0]  kind;
    logic        win;
    logic [31:0] data;
    logic [2:0]  idx;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  pix_in = 8'h00;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [31:0] data;
  logic        rowShift;
  logic        colShift;
  logic        win_valid;
  logic [1:0]  col_idx;
  logic [2:0]  row_idx;
  logic        frame_done;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  conv_row_loader #(
    .NUM_COL    (4),
    .NUM_ROW    (3),
    .DATA_WIDTH (8),
    .FRAME_ROWS (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .data       (data),
    .rowShift   (rowShift),
    .colShift   (colShift),
    .win_valid  (win_valid),
    .col_idx    (col_idx),
    .row_idx    (row_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_row(input logic [31:0] d, input int idx, input int ncol);
    exp_q.push_back('{kind: 2'(K_ROW), win: 1'b0, data: d, idx: 3'(idx)});
    for (int j = 0; j < ncol; j++) begin
      exp_q.push_back('{kind: 2'(K_COL), win: 1'b1, data: 32'h0, idx: 3'(j)});
    end
  endtask

  task automatic exp_done();
    exp_q.push_back('{kind: 2'(K_DONE), win: 1'b0, data: 32'h0, idx: 3'd0});
  endtask

  // Monitor: every pulse or window flag is compared against the next expected event.
  always @(negedge clk) begin
    ev_t act;
    ev_t e;
    if (reset && (rowShift || colShift || frame_done || win_valid)) begin
      act.kind = rowShift ? 2'(K_ROW) : colShift ? 2'(K_COL) : frame_done ? 2'(K_DONE) : 2'(K_NONE);
      act.win  = win_valid;
      act.data = rowShift ? data : 32'h0;
      act.idx  = rowShift ? row_idx : colShift ? {1'b0, col_idx} : 3'd0;
      chk("row_col_exclusive", {63'd0, rowShift & colShift}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 64'(act), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("event", 64'(act), 64'(e));
      end
    end
  end

  // Entered at a negedge; returns at the negedge right after the pixel was accepted.
  task automatic send_pix(input logic [7:0] p);
    int n;
    n = 0;
    pix_in    = p;
    pix_valid = 1'b1;
    while (!pix_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("pix_ready_wait", {63'd0, pix_ready}, 64'd1);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    flush     = 1'b0;
    repeat (8) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    reset = 1'b0;
    #1;
    chk("reset_outputs", {22'd0, data, pix_ready, rowShift, colShift, win_valid, frame_done, col_idx, row_idx}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("ready_first_cycle", {63'd0, pix_ready}, 64'd0);
    @(negedge clk);
    chk("ready_after_idle", {63'd0, pix_ready}, 64'd1);
  endtask

  task automatic scen1();
    do_reset();
    exp_row(32'h04030201, 0, 0);
    for (int i = 1; i <= 4; i++) send_pix(8'(i));
    chk("s1_rowshift", {63'd0, rowShift}, 64'd1);
    @(negedge clk);
    chk("s1_ready_next", {62'd0, pix_ready, colShift}, 64'd2);
  endtask

  initial begin
    // 1: single unprimed row
    scen1();

    // 2: three rows prime the window, then one four-step sweep
    do_reset();
    exp_row(32'h04030201, 0, 0);
    exp_row(32'h08070605, 1, 0);
    exp_row(32'h0C0B0A09, 2, 4);
    for (int i = 1; i <= 12; i++) send_pix(8'(i));
    repeat (4) begin
      @(negedge clk);
      chk("s2_colshift", {62'd0, colShift, win_valid}, 64'd3);
    end
    @(negedge clk);
    chk("s2_ready_after_slide", {62'd0, pix_ready, colShift}, 64'd2);

    // 3: full frame, frame_done, then re-priming in the next frame
    do_reset();
    exp_row(32'h23222120, 0, 0);
    exp_row(32'h27262524, 1, 0);
    exp_row(32'h2B2A2928, 2, 4);
    exp_row(32'h2F2E2D2C, 3, 4);
    exp_row(32'h33323130, 4, 4);
    exp_done();
    exp_row(32'h37363534, 0, 0);
    exp_row(32'h3B3A3938, 1, 0);
    for (int i = 0; i < 20; i++) send_pix(8'(8'h20 + i));
    repeat (4) @(negedge clk);
    @(negedge clk);
    chk("s3_frame_done", {63'd0, frame_done}, 64'd1);
    @(negedge clk);
    chk("s3_ready_after_done", {63'd0, pix_ready}, 64'd1);
    for (int i = 20; i < 28; i++) send_pix(8'(8'h20 + i));

    // 4: gapped pixel stream
    do_reset();
    exp_row(32'h04030201, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      send_pix(8'(i));
      if (i < 4) begin
        chk("s4_no_early_row", {63'd0, rowShift}, 64'd0);
        @(negedge clk);
      end
    end
    chk("s4_rowshift", {63'd0, rowShift}, 64'd1);

    // 5: flush with two pixels buffered and a colliding valid pixel
    do_reset();
    exp_row(32'h14131211, 0, 0);
    exp_row(32'h18171615, 1, 0);
    for (int i = 0; i < 10; i++) send_pix(8'(8'h11 + i));
    pix_in    = 8'h1B;
    pix_valid = 1'b1;
    flush     = 1'b1;
    chk("s5_ready_at_flush", {63'd0, pix_ready}, 64'd1);
    @(negedge clk);
    flush     = 1'b0;
    pix_valid = 1'b0;
    chk("s5_no_pulse_after_flush", {61'd0, rowShift, colShift, frame_done}, 64'd0);
    exp_row(32'hA3A2A1A0, 0, 0);
    exp_row(32'hB3B2B1B0, 1, 0);
    exp_row(32'hC3C2C1C0, 2, 4);
    for (int i = 0; i < 4; i++) send_pix(8'(8'hA0 + i));
    for (int i = 0; i < 4; i++) send_pix(8'(8'hB0 + i));
    for (int i = 0; i < 4; i++) send_pix(8'(8'hC0 + i));

    // 6: reset in the middle of the sweep, then the first scenario again
    do_reset();
    exp_row(32'h44434241, 0, 0);
    exp_row(32'h48474645, 1, 0);
    exp_row(32'h4C4B4A49, 2, 2);
    for (int i = 0; i < 12; i++) send_pix(8'(8'h41 + i));
    @(negedge clk);
    @(negedge clk);
    chk("s6_col_idx_before_abort", 64'(col_idx), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("s6_async_drop", {61'd0, colShift, win_valid, rowShift}, 64'd0);
    scen1();

    repeat (8) @(negedge clk);
    chk("final_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_row_loader.md
Name: conv_row_loader

Overview:
Upstream feeder for the convolution engine's 2D shift register file.
- Accepts a pixel stream (one pixel per cycle, valid/ready) and packs NUM_COL pixels into a row word.
- Pushes each completed row word into the RF with a one-cycle rowShift pulse.
- Once the window is primed (NUM_ROW rows loaded in the current frame), runs one full column rotation via colShift and flags each valid window alignment.

Parameters:
NUM_COL, `SHIFT_RF_2D_COL (default 8), pixels per row word / RF columns
NUM_ROW, `SHIFT_RF_2D_ROW (default 8), RF rows; rows needed to prime the window
DATA_WIDTH, `DATA_WIDTH (default 16), bits per pixel
FRAME_ROWS, 16, rows per frame; must be >= NUM_ROW

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous abort: discard partial row, restart frame
pix_in  in  DATA_WIDTH  input pixel
pix_valid  in  1  pix_in valid
pix_ready  out  1  loader can accept a pixel
data  out  NUM_COL*DATA_WIDTH  packed row word to RF
rowShift  out  1  one-cycle push of data into RF
colShift  out  1  one-cycle column rotate of RF
win_valid  out  1  RF currently holds a valid window
col_idx  out  clog2(NUM_COL)  alignment index of current window
row_idx  out  clog2(FRAME_ROWS)  index of most recently pushed row in frame
frame_done  out  1  one-cycle pulse after last row of frame processed

Behaviour:
- Reset (reset=0, async): state=IDLE, all counters 0, data=0, all outputs 0. First cycle after release: IDLE->FILL. pix_ready=0 during reset and in that cycle.
- States: IDLE, FILL, ROW, SLIDE, DONE. pix_ready = (state==FILL), decoded directly from the state register.
- FILL:
  - A pixel is accepted when pix_valid && pix_ready.
  - The k-th accepted pixel (k=0 first) lands in data[(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
  - data holds its previous contents outside the written slots.
  - The cycle the NUM_COL-th pixel is accepted, the next state is ROW.
- ROW:
  - Lasts exactly one cycle, with rowShift=1 and data stable.
  - rows_loaded increments, saturating at NUM_ROW.
  - row_idx = frame row count of the row just pushed (0-based), updated in the ROW cycle.
- Priming:
  - If rows_loaded (after the increment) < NUM_ROW: ROW->FILL, or ROW->DONE if this is row FRAME_ROWS-1.
  - Otherwise: ROW->SLIDE.
- SLIDE:
  - Lasts exactly NUM_COL cycles, with colShift=1 and win_valid=1 each cycle.
  - col_idx counts 0..NUM_COL-1.
  - win_valid in SLIDE cycle j describes RF content after j column shifts. The final shift restores the original alignment so the next rowShift lands aligned.
  - Then SLIDE->FILL, or SLIDE->DONE after row FRAME_ROWS-1.
- Latency: last pixel accepted in cycle t -> rowShift at t+1 -> colShift/win_valid at t+2..t+1+NUM_COL -> pix_ready=1 at t+2+NUM_COL. If unprimed, pix_ready=1 at t+2.
- DONE:
  - One cycle with frame_done=1.
  - Clears the frame row counter and rows_loaded (new frame re-primes), pixel slot counter = 0.
  - Next state FILL.
- flush=1 in any non-IDLE state:
  - Next state FILL; clears the slot counter, frame row counter and rows_loaded.
  - No rowShift/colShift/frame_done in the following cycle.
  - Flush wins over a simultaneous pixel accept; that pixel is dropped.
- Reset mid-frame aborts immediately; no partial pulses after reset asserts.
- Counters never wrap past their bounds: the slot counter is 0..NUM_COL-1, the frame row counter is 0..FRAME_ROWS-1.
- rowShift and colShift are never high in the same cycle.

Decomposition:
- Shared package (params.v): SHIFT_RF_2D_COL, SHIFT_RF_2D_ROW, DATA_WIDTH, SHIFT_RF_2D_ROW_WORD, new `CONV_FRAME_ROWS`, and state encodings `LDR_IDLE/FILL/ROW/SLIDE/DONE`.
- One sub-module: row_packer (slot counter plus data register; emits row_full on the NUM_COL-th accept; clear input driven by flush/DONE).

Test Plan:
Bench config: NUM_COL=4, NUM_ROW=3, FRAME_ROWS=5, DATA_WIDTH=8.
1. Reset then pixels 0x01..0x04 back-to-back -> pix_ready=0 first post-reset cycle; rowShift one cycle with data=0x04030201; no colShift (unprimed); pix_ready=1 next cycle.
2. Feed 12 pixels continuously -> 3 rowShift pulses; after the 3rd, colShift=win_valid=1 for 4 cycles with col_idx 0,1,2,3; pix_ready=1 the cycle after.
3. Feed 20 pixels -> rowShift rows 0..4 (row_idx 0..4); SLIDE after rows 2,3,4 only; frame_done one cycle after final SLIDE; next row_idx=0 and re-priming (no SLIDE after new rows 0,1).
4. Pixel gaps: pix_valid toggled every other cycle -> data packing unchanged (0x04030201); rowShift only after the 4th accept.
5. flush asserted with 2 pixels in buffer, concurrent with a valid pixel -> that pixel dropped; next 4 pixels 0xA0..0xA3 give data=0xA3A2A1A0; rows_loaded restarted (no SLIDE until 3 new rows).
6. reset asserted mid-SLIDE (col_idx=1) -> colShift, win_valid, rowShift drop to 0 asynchronously; after release, behaviour identical to scenario 1.
